// File: rtl/axil_single_master.sv
// axil_single_master: one-shot command/response front end issuing single AXI4-lite reads and writes
module axil_single_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_areset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RSP} state_t;
  state_t state, state_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic aw_done, w_done;
  logic accept, misaligned, ar_hs, r_hs, aw_hs, w_hs, b_hs, rsp_hs;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rsp_valid = state == RSP;
  assign m_axi_arvalid = state == RD_A;
  assign m_axi_rready = state == RD_D;
  assign m_axi_awvalid = state == WR_AW && !aw_done;
  assign m_axi_wvalid = state == WR_AW && !w_done;
  assign m_axi_bready = state == WR_B;
  assign m_axi_awaddr = addr;
  assign m_axi_araddr = addr;
  assign m_axi_wdata = wdata;
  assign m_axi_wstrb = wstrb;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign accept = cmd_valid && cmd_ready;
  assign misaligned = cmd_addr[1:0] != 2'b00;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs = m_axi_rvalid && m_axi_rready;
  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs = m_axi_wvalid && m_axi_wready;
  assign b_hs = m_axi_bvalid && m_axi_bready;
  assign rsp_hs = rsp_valid && rsp_ready;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !accept ? IDLE : misaligned ? RSP : cmd_write ? WR_AW : RD_A;
      RD_A:    state_nxt = ar_hs ? RD_D : RD_A;
      RD_D:    state_nxt = r_hs ? RSP : RD_D;
      WR_AW:   state_nxt = (aw_done || aw_hs) && (w_done || w_hs) ? WR_B : WR_AW;
      WR_B:    state_nxt = b_hs ? RSP : WR_B;
      RSP:     state_nxt = rsp_hs ? IDLE : RSP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state <= IDLE;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr <= cmd_addr;
        wdata <= cmd_wdata;
        wstrb <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        rsp_rdata <= '0;
        rsp_resp <= misaligned ? 2'b10 : 2'b00;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (r_hs) begin
        rsp_rdata <= m_axi_rdata;
        rsp_resp <= m_axi_rresp;
      end
      if (b_hs) begin
        rsp_rdata <= '0;
        rsp_resp <= m_axi_bresp;
      end
    end
  end
endmodule

// File: tb/tb_axil_single_master.sv
// tb_axil_single_master: randomized bench with a word-memory reference model and a random-wait slave
module tb_axil_single_master;
  logic m_axi_aclk = 1'b0;
  always #5 m_axi_aclk = ~m_axi_aclk;
  logic m_axi_areset, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, busy;
  logic [3:0] cmd_addr, cmd_wstrb, m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic [31:0] cmd_wdata, rsp_rdata, m_axi_wdata, m_axi_rdata;
  logic [1:0] rsp_resp, m_axi_bresp, m_axi_rresp;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  axil_single_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4)) dut (
    .m_axi_aclk(m_axi_aclk), .m_axi_areset(m_axi_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );
  int n_cmp = 0, n_err = 0;
  int wait_max = 0, n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0, t;
  bit hold_r = 0;
  logic [1:0] slv_resp = 2'b00;
  logic [3:0] cur_addr = '0, cur_wstrb = '0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] mem [4];
  logic [31:0] ref_mem [4];
  bit ar_got, aw_got, w_got, r_fire, b_fire, ar_wait, aw_wait, w_wait, ar_hs, aw_hs, w_hs;
  logic [3:0] ar_a, aw_a, ar_p, aw_p, w_s, w_sp;
  logic [31:0] w_d, w_p;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction
  function automatic bit go();
    return $urandom_range(0, wait_max) == 0;
  endfunction
  initial begin
    {m_axi_arready, m_axi_rvalid, m_axi_awready, m_axi_wready, m_axi_bvalid} = '0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_bresp = 2'b00;
    forever begin
      @(negedge m_axi_aclk);
      if (m_axi_areset) begin
        {m_axi_arready, m_axi_rvalid, m_axi_awready, m_axi_wready, m_axi_bvalid} = '0;
        {ar_got, aw_got, w_got, r_fire, b_fire, ar_wait, aw_wait, w_wait, ar_hs, aw_hs, w_hs} = '0;
      end else begin
        if (ar_wait) chk("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, ar_p});
        if (aw_wait) chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, aw_p});
        if (w_wait) chk("w_hold", {m_axi_wvalid, m_axi_wstrb, m_axi_wdata}, {1'b1, w_sp, w_p});
        if (ar_hs) chk("ar_drop", m_axi_arvalid, 0);
        if (aw_hs) chk("aw_drop", m_axi_awvalid, 0);
        if (w_hs) chk("w_drop", m_axi_wvalid, 0);
        if (r_fire) begin m_axi_rvalid = 0; n_r++; end
        if (b_fire) begin m_axi_bvalid = 0; n_b++; end
        if (ar_got && !m_axi_rvalid && !hold_r && go()) begin
          m_axi_rvalid = 1;
          m_axi_rdata = mem[ar_a[3:2]];
          m_axi_rresp = slv_resp;
          ar_got = 0;
        end
        if (aw_got && w_got && !m_axi_bvalid && go()) begin
          mem[aw_a[3:2]] = merge(mem[aw_a[3:2]], w_d, w_s);
          m_axi_bvalid = 1;
          m_axi_bresp = slv_resp;
          aw_got = 0;
          w_got = 0;
        end
        m_axi_arready = m_axi_arvalid && !ar_got && go();
        m_axi_awready = m_axi_awvalid && !aw_got && go();
        m_axi_wready = m_axi_wvalid && !w_got && go();
        ar_hs = m_axi_arvalid && m_axi_arready;
        aw_hs = m_axi_awvalid && m_axi_awready;
        w_hs = m_axi_wvalid && m_axi_wready;
        if (ar_hs) begin
          ar_got = 1; ar_a = m_axi_araddr; n_ar++;
          chk("araddr", {m_axi_arprot, m_axi_araddr}, {3'b000, cur_addr});
        end
        if (aw_hs) begin
          aw_got = 1; aw_a = m_axi_awaddr; n_aw++;
          chk("awaddr", {m_axi_awprot, m_axi_awaddr}, {3'b000, cur_addr});
        end
        if (w_hs) begin
          w_got = 1; w_d = m_axi_wdata; w_s = m_axi_wstrb; n_w++;
          chk("wdata", {m_axi_wstrb, m_axi_wdata}, {cur_wstrb, cur_wdata});
        end
        ar_wait = m_axi_arvalid && !m_axi_arready; ar_p = m_axi_araddr;
        aw_wait = m_axi_awvalid && !m_axi_awready; aw_p = m_axi_awaddr;
        w_wait = m_axi_wvalid && !m_axi_wready; w_p = m_axi_wdata; w_sp = m_axi_wstrb;
        r_fire = m_axi_rvalid && m_axi_rready;
        b_fire = m_axi_bvalid && m_axi_bready;
      end
    end
  end
  task automatic do_cmd(input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] resp, input int hold, input bit b2b);
    bit mis;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    logic [63:0] exp_bus;
    int lat, s_ar, s_r, s_aw, s_w, s_b;
    mis = a[1:0] != 2'b00;
    exp_d = '0;
    exp_r = mis ? 2'b10 : resp;
    if (!mis && wr) ref_mem[a[3:2]] = merge(ref_mem[a[3:2]], d, s);
    if (!mis && !wr) exp_d = ref_mem[a[3:2]];
    exp_bus = mis ? 64'h0 : wr ? 64'h00111 : 64'h11000;
    cur_addr = a; cur_wdata = d; cur_wstrb = s; slv_resp = resp;
    s_ar = n_ar; s_r = n_r; s_aw = n_aw; s_w = n_w; s_b = n_b;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    if (b2b) chk("b2b_ready", cmd_ready, 1);
    lat = 0;
    while (!cmd_ready && lat < 100) begin @(posedge m_axi_aclk); #1; lat++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    @(posedge m_axi_aclk); #1;
    cmd_valid = 0;
    rsp_ready = hold == 0;
    chk("accepted", {cmd_ready, busy}, 2'b01);
    lat = 1;
    while (!rsp_valid && lat < 300) begin @(posedge m_axi_aclk); #1; lat++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    if (wait_max == 0) chk("latency", lat, mis ? 1 : 3);
    chk("rsp_rdata", rsp_rdata, exp_d);
    chk("rsp_resp", rsp_resp, exp_r);
    chk("rsp_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge m_axi_aclk); #1;
      chk("rsp_hold", {rsp_valid, cmd_ready, busy, rsp_resp, rsp_rdata}, {3'b101, exp_r, exp_d});
    end
    rsp_ready = 1;
    @(posedge m_axi_aclk); #1;
    rsp_ready = 0;
    chk("rsp_done", {rsp_valid, busy, cmd_ready}, 3'b001);
    chk("bus_hs", {4'(n_ar - s_ar), 4'(n_r - s_r), 4'(n_aw - s_aw), 4'(n_w - s_w), 4'(n_b - s_b)}, exp_bus);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
  initial begin
    m_axi_areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[0] = 32'h1; ref_mem[0] = 32'h1;
    repeat (3) @(posedge m_axi_aclk);
    #1;
    chk("rst_ctrl", {cmd_ready, busy, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                     m_axi_rready, rsp_valid}, 8'h80);
    chk("rst_rsp", {rsp_resp, rsp_rdata}, 0);
    chk("rst_bus", {m_axi_awaddr, m_axi_araddr, m_axi_wstrb, m_axi_wdata}, 0);
    chk("rst_prot", {m_axi_awprot, m_axi_arprot}, 0);
    m_axi_areset = 0;
    wait_max = 1; do_cmd(0, 4'h0, 32'h0, 4'h0, 2'b00, 0, 0);
    wait_max = 3; do_cmd(1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0);
    wait_max = 0; do_cmd(0, 4'h6, 32'h0, 4'h0, 2'b00, 0, 0);
    wait_max = 1; do_cmd(0, 4'h4, 32'h0, 4'h0, 2'b10, 5, 0);
    wait_max = 0; hold_r = 1; cur_addr = 4'h0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h0;
    @(posedge m_axi_aclk); #1;
    cmd_valid = 0;
    t = 0;
    while (!m_axi_rready && t < 50) begin @(posedge m_axi_aclk); #1; t++; end
    chk("rd_d_reached", m_axi_rready, 1);
    m_axi_areset = 1;
    @(posedge m_axi_aclk); #1;
    m_axi_areset = 0;
    chk("mid_reset", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_rready,
                      rsp_valid, busy, cmd_ready}, 8'h01);
    hold_r = 0;
    mem[2] = 32'h00020003; ref_mem[2] = 32'h00020003;
    do_cmd(0, 4'h8, 32'h0, 4'h0, 2'b00, 0, 0);
    do_cmd(0, 4'h0, 32'h0, 4'h0, 2'b00, 0, 1);
    do_cmd(1, 4'h8, 32'hA5A55A5A, 4'h5, 2'b00, 0, 1);
    do_cmd(0, 4'h8, 32'h0, 4'h0, 2'b00, 0, 1);
    for (int i = 0; i < 80; i++) begin
      wait_max = $urandom_range(0, 3);
      do_cmd(1'($urandom), 4'($urandom), $urandom, 4'($urandom), 2'($urandom),
             $urandom_range(0, 3), 0);
    end
    wait_max = 2;
    for (int i = 0; i < 4; i++) do_cmd(0, 4'(i * 4), 32'h0, 4'h0, 2'b00, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axil_single_master.md
Name: axil_single_master

Overview:
- AXI4-lite initiator that turns a simple one-shot command/response interface into single AXI4-lite read or write transactions.
- It is the counterpart of the team's AXI4-lite register slaves, for example the system version block. Firmware-less logic (boot sequencers, self-test, version readback) uses it to read and write slave registers.
- One transaction outstanding at a time. Misaligned addresses are rejected locally and never reach the bus.

Parameters:
C_M_AXI_DATA_WIDTH, 32, AXI data width (32 only supported).
C_M_AXI_ADDR_WIDTH, 4, AXI address width (>=3).

Ports:
m_axi_aclk  in  1  sole clock
m_axi_areset  in  1  reset; one clock; reset is synchronous and active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address
cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data
cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data (0 for writes/errors)
rsp_resp  out  2  AXI response code, or 2'b10 for local misalign error
busy  out  1  high in any state other than IDLE
m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  standard AXI4-lite master channel, widths per parameters

Behaviour:
- Reset values:
  - All *valid outputs, m_axi_bready, m_axi_rready, rsp_valid and busy are 0; cmd_ready is 1.
  - rsp_rdata, rsp_resp, awaddr, araddr, wdata and wstrb are 0.
  - awprot and arprot are tied to 3'b000.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr/wdata/wstrb; cmd_ready drops the next cycle.
  - If cmd_addr[1:0]!=0, go to RSP with rsp_resp=2'b10 and rsp_rdata=0. No AXI activity.
  - Else read -> RD_A; write -> WR_AW.
- RD_A:
  - arvalid=1, starting the cycle after accept.
  - araddr is stable and held until the arvalid&arready handshake, then go to RD_D.
  - arvalid must never drop before the handshake.
- RD_D:
  - rready=1.
  - On rvalid&rready, capture rdata and rresp, then go to RSP.
- WR_AW:
  - awvalid and wvalid both assert the cycle after accept.
  - Each deasserts independently the cycle after its own handshake; the two may complete in either order or the same cycle.
  - When both are done, go to WR_B.
- WR_B:
  - bready=1.
  - On bvalid&bready, capture bresp, set rsp_rdata=0, then go to RSP.
- RSP:
  - rsp_valid=1, with data/resp stable until rsp_valid&rsp_ready, then go to IDLE.
  - cmd_ready=0 in RSP.
  - A new command can be accepted the cycle after the response handshake.
- Minimum latency, accept to rsp_valid, with a zero-wait slave (ready asserted same cycle):
  - Read: 3 cycles (accept, AR hs, R hs, rsp).
  - Write: 3 cycles.
  - Misaligned: 1 cycle.
- No timeout: the block waits indefinitely on the slave, and busy stays high.
- Reset mid-transaction: the next state is IDLE and all valids drop immediately. The slave is required to share the same reset domain, so no AXI rule is violated.
- rsp_resp is passed through unmodified, including SLVERR and DECERR from the slave.

Test Plan:
- Read addr 0x0, slave returns rdata 0x00000001 rresp 00 with arready 1 cycle after arvalid -> single AR handshake with araddr=0x0; rsp_rdata=0x00000001, rsp_resp=00; busy low after rsp handshake.
- Write addr 0x4 data 0xDEADBEEF strb 0xF; slave gives wready 3 cycles before awready, bvalid 2 cycles later -> wvalid drops after its own handshake; awvalid held until awready; exactly one B handshake; rsp_resp=00, rsp_rdata=0.
- Read addr 0x6 -> no arvalid ever asserted; rsp_valid the cycle after accept with rsp_resp=10, rsp_rdata=0.
- Slave returns rresp=10 and rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable for all 5 cycles; cmd_ready=0 throughout.
- m_axi_areset high while in RD_D (rvalid not yet seen) -> next cycle all valids 0, cmd_ready=1, busy=0; a subsequent read of 0x8 (slave returning 0x00020003) completes normally.
- Back-to-back: read 0x0, write 0x8, read 0x8 with cmd_valid held and rsp_ready=1 -> three transactions in order, never two outstanding, each accept occurring the cycle after the prior response handshake.
